// File: rtl/des_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des_pkg                                                      |
// | Description : DES permutation tables, key schedule, S-boxes and helpers.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package des_pkg;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [27:0] c;
    logic [27:0] d;
    logic        dec;
  } stage_t;

  // Tables hold DES 1-based, MSB-first bit numbers of the source word.
  localparam int C_IP [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int C_FP [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int C_E [0:47] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int C_P [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int C_PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int C_PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int C_SHIFT [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Entry (row*16 + col) lives at bits [255 - 4*entry -: 4].
  localparam logic [255:0] C_SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-C_IP[j]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-C_FP[j]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[47-j] = x[32-C_E[j]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[31-j] = x[32-C_P[j]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++) y[55-j] = x[64-C_PC1[j]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[47-j] = x[56-C_PC2[j]];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [255:0] tbl, input logic [5:0] b);
    int idx;
    idx = {26'd0, b[5], b[0], b[4:1]};
    return tbl[255-4*idx -: 4];
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_expand(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) s[31-4*i -: 4] = sbox(C_SBOX[i], x[47-6*i -: 6]);
    return p_perm(s);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (x >> n) | (x << (28 - n));
  endfunction

  // Decryption walks the schedule backwards; round 1 uses the full-turn (unrotated) key.
  function automatic int key_shift(input int round, input logic dec);
    if (!dec) return C_SHIFT[round-1];
    if (round == 1) return 0;
    return C_SHIFT[17-round];
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_round.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des_round                                                    |
// | Description : One DES round: key rotation, PC2, f-function, stage register.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module des_round
  import des_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t i_stage,
  output stage_t o_stage
);

  localparam int ENC_SHIFT = key_shift(ROUND, 1'b0);
  localparam int DEC_SHIFT = key_shift(ROUND, 1'b1);

  stage_t      stage_d;
  stage_t      stage_q;
  logic [47:0] round_key;

  always_comb begin
    stage_d = i_stage;
    if (i_stage.dec) begin
      stage_d.c = rotr28(i_stage.c, DEC_SHIFT);
      stage_d.d = rotr28(i_stage.d, DEC_SHIFT);
    end else begin
      stage_d.c = rotl28(i_stage.c, ENC_SHIFT);
      stage_d.d = rotl28(i_stage.d, ENC_SHIFT);
    end
    round_key = pc2_perm({stage_d.c, stage_d.d});
    stage_d.l = i_stage.r;
    stage_d.r = i_stage.l ^ f_func(i_stage.r, round_key);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign o_stage = stage_q;

endmodule
`default_nettype wire

// File: rtl/des.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des                                                          |
// | Description : Fully pipelined DES core, one block per clock, 16 rounds.    |
// |               DES_OUT_REG_EN adds an output register (latency 17).         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module des
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] desOut,
  input  logic [63:0] desIn,
  input  logic [63:0] key,
  input  logic        decrypt
);

  stage_t      stage_d;
  stage_t      stage_q;
  stage_t      stage_pipe [0:16];
  logic [63:0] ip_blk;
  logic [55:0] pc1_key;

  always_comb begin
    ip_blk      = ip_perm(desIn);
    pc1_key     = pc1_perm(key);
    stage_d.l   = ip_blk[63:32];
    stage_d.r   = ip_blk[31:0];
    stage_d.c   = pc1_key[55:28];
    stage_d.d   = pc1_key[27:0];
    stage_d.dec = decrypt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign stage_pipe[0] = stage_q;

  for (genvar i = 1; i <= 16; i++) begin : g_round
    des_round #(
      .ROUND (i)
    ) u_round (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_stage (stage_pipe[i-1]),
      .o_stage (stage_pipe[i])
    );
  end

`ifdef DES_OUT_REG_EN
  logic [63:0] out_d;
  logic [63:0] out_q;

  always_comb out_d = fp_perm({stage_pipe[16].r, stage_pipe[16].l});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign desOut = out_q;
`else
  // Halves swap after the last round before the final permutation.
  always_comb desOut = fp_perm({stage_pipe[16].r, stage_pipe[16].l});
`endif

endmodule
`default_nettype wire

// File: tb/tb_des.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for des: randomized blocks plus known-answer vectors, scoreboard-checked.
module tb_des;
  import des_pkg::*;

`ifdef DES_OUT_REG_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [63:0] desOut;
  logic [63:0] desIn   = '0;
  logic [63:0] key     = '0;
  logic        decrypt = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  int rel_edge = 0;

  typedef struct {
    logic [63:0] exp;
    int          edge_n;
    int          tag;
  } exp_t;

  exp_t exp_q[$];

  des dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .desOut  (desOut),
    .desIn   (desIn),
    .key     (key),
    .decrypt (decrypt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %016h expected %016h", nm, act, exp);
    end
  endtask

  // Textbook DES on 1-based bit arrays: full subkey list, reversed for decryption.
  function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] blk, input bit dec);
    bit kb [1:64];
    bit bb [1:64];
    bit cd [1:56];
    bit ks [1:16][1:48];
    bit l  [1:32];
    bit r  [1:32];
    bit er [1:48];
    bit sb [1:32];
    bit pre [1:64];
    bit t;
    int row, col, kr;
    logic [255:0] tbl;
    logic [3:0]   v;
    logic [63:0]  res;
    for (int i = 1; i <= 64; i++) begin
      kb[i] = k[64-i];
      bb[i] = blk[64-i];
    end
    for (int i = 1; i <= 56; i++) cd[i] = kb[C_PC1[i-1]];
    for (int n = 1; n <= 16; n++) begin
      for (int s = 0; s < C_SHIFT[n-1]; s++) begin
        t = cd[1];
        for (int j = 1; j < 28; j++) cd[j] = cd[j+1];
        cd[28] = t;
        t = cd[29];
        for (int j = 29; j < 56; j++) cd[j] = cd[j+1];
        cd[56] = t;
      end
      for (int j = 1; j <= 48; j++) ks[n][j] = cd[C_PC2[j-1]];
    end
    for (int i = 1; i <= 32; i++) begin
      l[i] = bb[C_IP[i-1]];
      r[i] = bb[C_IP[i+31]];
    end
    for (int n = 1; n <= 16; n++) begin
      kr = dec ? 17 - n : n;
      for (int j = 1; j <= 48; j++) er[j] = r[C_E[j-1]] ^ ks[kr][j];
      for (int s = 0; s < 8; s++) begin
        row = 2 * int'(er[6*s+1]) + int'(er[6*s+6]);
        col = 8 * int'(er[6*s+2]) + 4 * int'(er[6*s+3]) + 2 * int'(er[6*s+4]) + int'(er[6*s+5]);
        tbl = C_SBOX[s];
        v   = tbl[255-4*(16*row+col) -: 4];
        for (int b = 0; b < 4; b++) sb[4*s+1+b] = v[3-b];
      end
      for (int j = 1; j <= 32; j++) begin
        t    = l[j] ^ sb[C_P[j-1]];
        l[j] = r[j];
        r[j] = t;
      end
    end
    for (int i = 1; i <= 32; i++) begin
      pre[i]    = r[i];
      pre[i+32] = l[i];
    end
    res = '0;
    for (int j = 1; j <= 64; j++) res[64-j] = pre[C_FP[j-1]];
    return res;
  endfunction

  function automatic void push_exp(input logic [63:0] exp, input int tag);
    exp_t e;
    e.exp    = exp;
    e.edge_n = edge_cnt + 1;
    e.tag    = tag;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [63:0] k, input logic [63:0] d, input logic dc,
                       input logic [63:0] exp, input int tag);
    @(negedge clk);
    key     = k;
    desIn   = d;
    decrypt = dc;
    push_exp(exp, tag);
  endtask

  task automatic drive_rand(input int tag);
    logic [63:0] k, d;
    logic        dc;
    k  = {$urandom, $urandom};
    d  = {$urandom, $urandom};
    dc = 1'($urandom_range(0, 1));
    drive(k, d, dc, des_model(k, d, dc), tag);
  endtask

  // Monitor: zero while in reset, otherwise compare each block when its latency elapses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || edge_cnt == rel_edge) begin
      check("reset_zero", desOut, 64'h0);
    end else if (exp_q.size() > 0) begin
      if (exp_q[0].edge_n + LAT == edge_cnt) begin
        e = exp_q.pop_front();
        check($sformatf("blk%0d", e.tag), desOut, e.exp);
      end else if (exp_q[0].edge_n + LAT < edge_cnt) begin
        e = exp_q.pop_front();
        check($sformatf("blk%0d_missed", e.tag), 64'hDEAD_DEAD_DEAD_DEAD, e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    // Release at a negedge and present the first block for the very next edge.
    rst_n    = 1'b1;
    rel_edge = edge_cnt;
    key      = 64'h10316E028C8F3B4A;
    desIn    = 64'h0;
    decrypt  = 1'b0;
    push_exp(64'h82DCBAFBDEAB6602, 1);
    drive(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 2);
    drive(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 3);
    drive(64'h0,                64'h0,                1'b0, 64'h8CA64DE9C1B123A7, 4);
    drive(64'h0101010101010101, 64'h0,                1'b0, 64'h8CA64DE9C1B123A7, 5);
    drive(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 6);
    drive(64'h10316E028C8F3B4A, 64'h0,                1'b0, 64'h82DCBAFBDEAB6602, 7);
    for (int i = 0; i < 200; i++) drive_rand(100 + i);

    // Asynchronous reset in the middle of a busy pipeline.
    @(negedge clk);
    key     = '0;
    desIn   = '0;
    decrypt = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_now", desOut, 64'h0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    rel_edge = edge_cnt;
    push_exp(64'h8CA64DE9C1B123A7, 500);
    drive(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 501);
    for (int i = 0; i < 30; i++) drive_rand(600 + i);

    repeat (LAT + 3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
